// File: rtl/fc_seq_pkg.sv
// Shared types and helpers for the fully-connected layer sequencer.
//   state_e   : sequencer phases (load frame, wait for layer, capture, stream out)
//   sat_shift : unsigned right shift followed by saturation to a given width
package fc_seq_pkg;

  typedef enum logic [1:0] {
    S_LOAD    = 2'd0,
    S_SETTLE  = 2'd1,
    S_CAPTURE = 2'd2,
    S_DRAIN   = 2'd3
  } state_e;

  // Counter width for a modulus n; never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // z >> shift, clamped to 2^width-1 (z unsigned, width <= 32).
  function automatic logic [31:0] sat_shift(input logic [63:0] z,
                                            input int unsigned shift,
                                            input int unsigned width);
    logic [63:0] v;
    logic [63:0] lim;
    v   = z >> shift;
    lim = (64'd1 << width) - 64'd1;
    if (v > lim) v = lim;
    return v[31:0];
  endfunction

endpackage

// File: rtl/fc_requant.sv
// One result lane: requantize a neuron output to WIDTH bits.
//   z_i : unsigned neuron output (post-ReLU)
//   q_c : saturate(z_i >> SHIFT), combinational
module fc_requant
  import fc_seq_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned Z_WIDTH = 22,
  parameter int unsigned SHIFT   = 8
) (
  input  logic [Z_WIDTH-1:0] z_i,
  output logic [WIDTH-1:0]   q_c
);

  assign q_c = WIDTH'(sat_shift(64'(z_i), SHIFT, WIDTH));

endmodule

// File: rtl/fc_layer_seq.sv
// Sequencer around one combinational fully-connected layer.
// Loads an activation frame into x_buf, waits SETTLE cycles for the layer,
// captures and requantizes all N_OUT results, then streams them out.
//   clk, rst             : clock, asynchronous active-high reset
//   in_valid/ready/data/last : activation byte stream
//   x_buf                : activation register bank feeding the layer
//   z_in                 : layer outputs (unsigned)
//   out_valid/ready/data/last: requantized result stream
//   busy                 : not idle (idle = LOAD with no beat received)
//   frame_err            : sticky framing-error flag
module fc_layer_seq
  import fc_seq_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned IN      = 400,
  parameter int unsigned N_OUT   = 120,
  parameter int unsigned Z_WIDTH = 22,
  parameter int unsigned SETTLE  = 2,
  parameter int unsigned SHIFT   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic               in_last,
  output logic [WIDTH-1:0]   x_buf [0:IN-1],
  input  logic [Z_WIDTH-1:0] z_in  [0:N_OUT-1],
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_last,
  output logic               busy,
  output logic               frame_err
);

  localparam int unsigned IDX_W  = cnt_w(IN);
  localparam int unsigned OIDX_W = cnt_w(N_OUT);
  localparam int unsigned SCNT_W = cnt_w(SETTLE + 1);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [OIDX_W-1:0]   oidx_q, oidx_d;
  logic [SCNT_W-1:0]   scnt_q, scnt_d;
  logic                frame_err_q, frame_err_d;
  logic                in_ready_q, in_ready_d;
  logic                out_valid_q, out_valid_d;
  logic                out_last_q, out_last_d;
  logic                busy_q, busy_d;
  logic [WIDTH-1:0]    out_data_q, out_data_d;
  logic [WIDTH-1:0]    x_buf_q [0:IN-1];
  logic [WIDTH-1:0]    res_q   [0:N_OUT-1];
  logic [WIDTH-1:0]    lane_c  [0:N_OUT-1];
  logic                wr_en_c, clr_c, cap_c, last_idx_c;

  // Requantization lanes, sampled into res_q only in CAPTURE.
  for (genvar j = 0; j < N_OUT; j++) begin : g_lane
    fc_requant #(.WIDTH(WIDTH), .Z_WIDTH(Z_WIDTH), .SHIFT(SHIFT)) u_rq (
      .z_i (z_in[j]),
      .q_c (lane_c[j])
    );
  end

  assign last_idx_c = (idx_q == IDX_W'(IN - 1));

  // Next state, counters and registered-output next values.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    oidx_d      = oidx_q;
    scnt_d      = scnt_q;
    frame_err_d = frame_err_q;
    wr_en_c     = 1'b0;
    clr_c       = 1'b0;
    cap_c       = 1'b0;
    case (state_q)
      S_LOAD: begin
        if (in_valid) begin
          wr_en_c = 1'b1;
          // in_last must coincide exactly with the final slot
          if (in_last != last_idx_c) frame_err_d = 1'b1;
          if (in_last || last_idx_c) begin
            state_d = S_SETTLE;
            scnt_d  = SCNT_W'(SETTLE - 1);
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      S_SETTLE: begin
        if (scnt_q == '0) state_d = S_CAPTURE;
        else              scnt_d  = scnt_q - SCNT_W'(1);
      end
      S_CAPTURE: begin
        cap_c   = 1'b1;
        state_d = S_DRAIN;
        oidx_d  = '0;
      end
      S_DRAIN: begin
        // out_valid is high for the whole of DRAIN
        if (out_ready) begin
          if (oidx_q == OIDX_W'(N_OUT - 1)) begin
            clr_c   = 1'b1;
            state_d = S_LOAD;
            oidx_d  = '0;
          end else begin
            oidx_d = oidx_q + OIDX_W'(1);
          end
        end
      end
      default: state_d = S_LOAD;
    endcase

    in_ready_d  = (state_d == S_LOAD);
    out_valid_d = (state_d == S_DRAIN);
    busy_d      = !((state_d == S_LOAD) && (idx_d == '0));
    out_last_d  = (state_d == S_DRAIN) && (oidx_d == OIDX_W'(N_OUT - 1));
    out_data_d  = '0;
    // Entering DRAIN the first result is still on the lane, not yet in res_q.
    if (state_d == S_DRAIN) out_data_d = cap_c ? lane_c[0] : res_q[oidx_d];
  end

  // Control and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_LOAD;
      idx_q       <= '0;
      oidx_q      <= '0;
      scnt_q      <= '0;
      frame_err_q <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      oidx_q      <= oidx_d;
      scnt_q      <= scnt_d;
      frame_err_q <= frame_err_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      out_data_q  <= out_data_d;
    end
  end

  // Activation bank; cleared after each frame so short frames read zeros.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < IN; i++) x_buf_q[i] <= '0;
    end else if (clr_c) begin
      for (int i = 0; i < IN; i++) x_buf_q[i] <= '0;
    end else if (wr_en_c) begin
      x_buf_q[idx_q] <= in_data;
    end
  end

  // Result bank, loaded in one shot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j < N_OUT; j++) res_q[j] <= '0;
    end else if (cap_c) begin
      for (int j = 0; j < N_OUT; j++) res_q[j] <= lane_c[j];
    end
  end

  assign x_buf     = x_buf_q;
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_data  = out_data_q;
  assign busy      = busy_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_fc_layer_seq.sv
// Self-checking bench for fc_layer_seq: frame-level model plus literal checks.
module tb_fc_layer_seq;

  localparam int unsigned WIDTH   = 8;
  localparam int unsigned IN      = 400;
  localparam int unsigned N_OUT   = 120;
  localparam int unsigned Z_WIDTH = 22;
  localparam int unsigned SETTLE  = 2;
  localparam int unsigned SHIFT   = 8;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               in_valid = 1'b0;
  logic               in_last = 1'b0;
  logic               out_ready = 1'b1;
  logic [WIDTH-1:0]   in_data = '0;
  logic               in_ready, out_valid, out_last, busy, frame_err;
  logic [WIDTH-1:0]   out_data;
  logic [WIDTH-1:0]   x_buf [0:IN-1];
  logic [Z_WIDTH-1:0] z_in  [0:N_OUT-1];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fc_layer_seq #(
    .WIDTH(WIDTH), .IN(IN), .N_OUT(N_OUT), .Z_WIDTH(Z_WIDTH),
    .SETTLE(SETTLE), .SHIFT(SHIFT)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .x_buf(x_buf), .z_in(z_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .frame_err(frame_err)
  );

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- frame-level model ----------------
  // phase 0: collecting a frame, 1: layer settling, 2: results streaming
  int               m_phase = 0;
  int               m_cnt = 0;
  int               m_wait = 0;
  int               m_pos = 0;
  bit               m_err = 1'b0;
  logic [WIDTH-1:0] m_x [0:IN-1];
  int               m_q [0:N_OUT-1];

  task automatic model_step();
    if (rst) begin
      m_phase = 0; m_cnt = 0; m_wait = 0; m_pos = 0; m_err = 1'b0;
      for (int i = 0; i < IN; i++) m_x[i] = '0;
    end else begin
      case (m_phase)
        0: if (in_valid) begin
             m_x[m_cnt] = in_data;
             if (in_last != (m_cnt == IN - 1)) m_err = 1'b1;
             m_cnt++;
             if (in_last || m_cnt == IN) begin
               m_phase = 1;
               m_wait  = SETTLE + 1;
             end
           end
        1: begin
             m_wait--;
             if (m_wait == 0) begin
               for (int j = 0; j < N_OUT; j++) begin
                 int v;
                 v = int'(z_in[j] >> SHIFT);
                 m_q[j] = (v > 255) ? 255 : v;
               end
               m_pos   = 0;
               m_phase = 2;
             end
           end
        default: if (out_ready) begin
             m_pos++;
             if (m_pos == N_OUT) begin
               m_phase = 0;
               m_cnt   = 0;
               for (int i = 0; i < IN; i++) m_x[i] = '0;
             end
           end
      endcase
    end
  endtask

  initial begin
    for (int i = 0; i < IN; i++) m_x[i] = '0;
    for (int j = 0; j < N_OUT; j++) m_q[j] = 0;
    forever begin
      @(posedge clk or posedge rst);
      model_step();
    end
  end

  // Compare DUT with the model on every falling edge.
  initial forever begin
    int bad;
    @(negedge clk);
    check("in_ready", in_ready, m_phase == 0);
    check("out_valid", out_valid, m_phase == 2);
    check("busy", busy, !(m_phase == 0 && m_cnt == 0));
    check("frame_err", frame_err, m_err);
    bad = -1;
    for (int i = 0; i < IN; i++) if (x_buf[i] !== m_x[i] && bad < 0) bad = i;
    check("x_buf_first_diff_index", bad, -1);
    if (m_phase == 2) begin
      check("out_data", out_data, m_q[m_pos]);
      check("out_last", out_last, m_pos == N_OUT - 1);
    end
  end

  // Accepted result beats of the current frame.
  int got[$];
  initial forever begin
    @(negedge clk);
    if (!rst && out_valid && out_ready) got.push_back(int'(out_data));
  end

  // ---------------- stimulus ----------------
  task automatic send_frame(input int n, input int pat, input bit with_last);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = (pat < 0) ? WIDTH'(i % 256) : WIDTH'(pat);
      in_last  = with_last && (i == n - 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic drain(input bit stall, input bit hold_in, input int max_beats);
    int k, beats, guard;
    bit v, l, done;
    k = 0; beats = 0; guard = 0; done = 1'b0;
    while (!done && guard < 4000) begin
      out_ready = stall ? (k % 4 == 0 || k % 4 == 3) : 1'b1;
      in_valid  = hold_in;
      in_data   = 8'hAA;
      in_last   = 1'b0;
      v = out_valid;
      l = out_last;
      if (v && out_ready) beats++;
      @(posedge clk); #1;
      if (v && out_ready && (l || beats == max_beats)) done = 1'b1;
      k++; guard++;
    end
    check("drain_done_in_budget", int'(done), 1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic set_ramp(input int step);
    for (int j = 0; j < N_OUT; j++) z_in[j] = Z_WIDTH'(j * step);
  endtask

  initial begin
    int lat;
    set_ramp(0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_data", out_data, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_err", frame_err, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic frame
    set_ramp(300);
    got.delete();
    send_frame(IN, -1, 1'b1);
    wait_valid(lat);
    check("t1_latency", lat, SETTLE + 1);
    drain(1'b0, 1'b0, N_OUT);
    check("t1_count", got.size(), N_OUT);
    check("t1_res0", got[0], 0);
    check("t1_res1", got[1], 1);
    check("t1_res119", got[119], 139);
    check("t1_frame_err", frame_err, 0);

    // Saturation
    set_ramp(0);
    z_in[0] = 22'h3FFFFF;
    z_in[1] = 22'(255 << 8);
    z_in[2] = 22'(256 << 8);
    z_in[3] = 22'd255;
    got.delete();
    send_frame(IN, 8'h11, 1'b1);
    wait_valid(lat);
    drain(1'b0, 1'b0, N_OUT);
    check("t2_sat0", got[0], 255);
    check("t2_sat1", got[1], 255);
    check("t2_sat2", got[2], 255);
    check("t2_small3", got[3], 0);

    // Backpressure with in_valid held during drain
    set_ramp(517);
    got.delete();
    send_frame(IN, -1, 1'b1);
    wait_valid(lat);
    drain(1'b1, 1'b1, N_OUT);
    check("t3_count", got.size(), N_OUT);
    for (int k = 0; k < N_OUT; k++) check("t3_seq", got[k], (k * 517) / 256);
    check("t3_xbuf0_cleared", x_buf[0], 0);
    check("t3_idle", busy, 0);

    // Short frame after a full 0xFF frame
    got.delete();
    send_frame(IN, 8'hFF, 1'b1);
    wait_valid(lat);
    drain(1'b0, 1'b0, N_OUT);
    send_frame(10, 8'h33, 1'b1);
    check("t4_frame_err", frame_err, 1);
    check("t4_xbuf9", x_buf[9], 8'h33);
    check("t4_xbuf10", x_buf[10], 0);
    check("t4_xbuf399", x_buf[399], 0);
    check("t4_in_ready_settle", in_ready, 0);
    wait_valid(lat);
    check("t4_latency", lat, SETTLE + 1);
    drain(1'b0, 1'b0, N_OUT);

    // Reset in the middle of DRAIN
    set_ramp(300);
    send_frame(IN, 8'h77, 1'b1);
    wait_valid(lat);
    drain(1'b0, 1'b0, 50);
    #1 rst = 1'b1;
    #1;
    check("t6_out_valid", out_valid, 0);
    check("t6_in_ready", in_ready, 1);
    check("t6_busy", busy, 0);
    check("t6_frame_err", frame_err, 0);
    check("t6_xbuf0", x_buf[0], 0);
    check("t6_xbuf399", x_buf[399], 0);
    #3 rst = 1'b0;
    @(posedge clk); #1;
    got.delete();
    send_frame(IN, -1, 1'b1);
    wait_valid(lat);
    drain(1'b0, 1'b0, N_OUT);
    check("t6_count", got.size(), N_OUT);
    check("t6_res50", got[50], 58);
    check("t6_res119", got[119], 139);

    // Missing in_last
    got.delete();
    send_frame(IN, 8'h42, 1'b0);
    check("t5_frame_err", frame_err, 1);
    check("t5_in_ready", in_ready, 0);
    wait_valid(lat);
    drain(1'b0, 1'b0, N_OUT);
    check("t5_count", got.size(), N_OUT);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fc_layer_seq.md
Name: fc_layer_seq

Overview:
- Sequencer wrapped around one fully-connected layer: N_OUT combinational constant-weight neuron instances (`layer`), each with IN inputs.
- Accepts an activation frame as a byte stream and holds it in an input register bank that drives every neuron's x port.
- Waits a programmable settle time for the combinational multiplier/adder trees, then captures all neuron results at once.
- Requantizes each result to WIDTH bits and streams the results out serially to the next layer.

Parameters:
- WIDTH, 8, activation width in bits, both in and out.
- IN, 400, activations per frame.
- N_OUT, 120, number of neurons (results per frame).
- Z_WIDTH, 22, width of each neuron's z output.
- SETTLE, 2, clock cycles allowed for the combinational layer to settle (multicycle path); minimum 1.
- SHIFT, 8, right shift applied to z before saturation.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  activation beat valid
- in_ready  out  1  controller can accept a beat
- in_data  in  WIDTH  activation value
- in_last  in  1  marks the final beat of a frame
- x_buf  out  WIDTH x [0:IN-1]  register bank, wired to every neuron's x
- z_in  in  Z_WIDTH x [0:N_OUT-1]  neuron outputs; non-negative, post-ReLU
- out_valid  out  1  result beat valid
- out_ready  in  1  downstream accepts
- out_data  out  WIDTH  requantized result
- out_last  out  1  final result of the frame
- busy  out  1  high in any state other than LOAD with index 0
- frame_err  out  1  sticky framing-error flag

Behaviour:
- Reset is asynchronous: state=LOAD, all counters 0, x_buf all zero, result registers zero, frame_err 0.
- Reset values of outputs: in_ready 1, out_valid 0, out_last 0, out_data 0, busy 0.
- States: LOAD → SETTLE → CAPTURE → DRAIN → LOAD.
- LOAD
  - in_ready = 1.
  - On in_valid & in_ready: x_buf[idx] <= in_data and idx increments.
  - Frame ends on an accepted beat with idx==IN-1 or with in_last=1; the next state is SETTLE with scnt=SETTLE-1 and idx cleared.
  - in_last on a beat with idx<IN-1 (short frame): frame_err <= 1. Unwritten entries keep zero because the buffer is cleared at the end of DRAIN.
  - idx==IN-1 accepted without in_last: frame_err <= 1 and the frame still completes.
- SETTLE
  - in_ready = 0; x_buf is held stable.
  - scnt decrements each cycle; at scnt==0 go to CAPTURE.
  - Total cycles from the last input acceptance to CAPTURE = SETTLE.
- CAPTURE (one cycle)
  - For every j: res[j] <= sat(z_in[j] >> SHIFT).
  - sat(v) = v if v < 2^WIDTH, else 2^WIDTH-1. z is treated as unsigned.
  - Next state DRAIN with oidx=0.
- DRAIN
  - out_valid = 1, out_data = res[oidx], out_last = (oidx==N_OUT-1).
  - out_data and out_last are held stable while out_ready is 0.
  - On handshake oidx increments.
  - On handshake with out_last: x_buf is cleared to zero, state goes to LOAD, out_valid drops the next cycle.
- Throughput: no overlap between frames. in_ready is 0 from SETTLE through the end of DRAIN.
- frame_err is cleared only by rst.
- Reset mid-frame in any state returns to the reset state immediately. Partial input and results are discarded; no out_valid glitch.
- Counter widths: idx is $clog2(IN), oidx is $clog2(N_OUT), scnt is $clog2(SETTLE+1).
- Integration note: the multicycle constraint on x_buf→res is set to SETTLE.

Decomposition:
- Package fc_seq_pkg:
  - state enum {LOAD, SETTLE, CAPTURE, DRAIN}.
  - Function sat_shift(z, SHIFT, WIDTH).
- One natural sub-module: fc_requant, per-lane shift and saturate, instantiated N_OUT times in CAPTURE.
- The neuron instances (layer) live in the parent wrapper, not in this block.

Test Plan:
1. Basic frame
   - Stimulus: IN=400 beats with in_data=idx%256 and in_last on beat 399; model z_in[j]=j*300.
   - Response: CAPTURE occurs exactly SETTLE=2 cycles after the last accept; out_data sequence is sat((j*300)>>8) (j=0→0, j=1→1, j=119→139 saturates to 139, which is <255); out_last on j=119; frame_err=0.
2. Saturation
   - Stimulus: z_in[0]=22'h3FFFFF, z_in[1]=255<<8, z_in[2]=256<<8.
   - Response: out_data = 255, 255, 255.
   - Stimulus: z_in[3]=255.
   - Response: out_data = 0.
3. Backpressure
   - Stimulus: out_ready toggles 1-0-0-1 during DRAIN.
   - Response: out_data is held during stalls; exactly N_OUT beats; no duplicates or skips.
   - Stimulus: in_valid held high during DRAIN.
   - Response: in_ready=0 and no x_buf writes.
4. Short frame
   - Stimulus: in_last on beat 9, after a previous full frame of 0xFF.
   - Response: frame_err=1; x_buf[10..399]=0; SETTLE is entered.
5. Missing in_last
   - Stimulus: 400 beats with no in_last.
   - Response: frame completes; frame_err=1.
6. Reset mid-DRAIN
   - Stimulus: rst pulsed at oidx=50.
   - Response: out_valid=0 asynchronously; in_ready=1, busy=0, x_buf all zero.
   - Stimulus: a new full frame after reset.
   - Response: the frame yields N_OUT correct results.
